thr_rr_arbiter: RTL and testbench

Parametrised round-robin arbiter built on priority-to-thermometer masking. Each cycle it selects one of `WIDTH` requesters, presents a registered one-hot grant with a valid/ready handshake, and rotates priority past the last accepted requester. It sits between N request sources and a single shared consumer (bus port, FIFO write side), replacing ad-hoc fixed-priority encoders.

---
 rtl/thr_rr_arbiter.sv | 115 +++++++++++
 tb/tb_thr_rr_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/thr_rr_arbiter.sv
// Round-robin arbiter: thermometer-masked lowest-set-bit selection, registered one-hot grant
// with valid/ready handshake. Define THR_RR_ARB_LOCK_EN to hold an unaccepted grant stable.

module thr_rr_thermo #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] thr
);
   // thr[i] = |x[i:0]; a running OR keeps X above the first set bit from leaking down
   always_comb begin
      logic acc;
      acc = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         acc    = acc | x[i];
         thr[i] = acc;
      end
   end
endmodule

module thr_rr_arbiter #(
   parameter int WIDTH = 8,
   parameter int IDXW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] req,
   output logic [WIDTH-1:0] gnt,
   output logic [IDXW-1:0]  gnt_idx,
   output logic             gnt_vld,
   input  logic             gnt_rdy
);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] msk, msk_nxt;
   logic [WIDTH-1:0] gnt_nxt;
   logic [IDXW-1:0]  idx_nxt;
   logic [WIDTH-1:0] gnt_thr;
   logic [WIDTH-1:0] mreq, sel_src, sel_thr, sel_oh;
   logic [IDXW-1:0]  sel_idx;
   logic             xfer;

   assign gnt_vld = (state == GRANT);
   assign xfer    = gnt_vld & gnt_rdy;

   // Priority moves strictly past the accepted index; index WIDTH-1 empties the mask (wrap).
   thr_rr_thermo #(.WIDTH(WIDTH)) u_gnt_thr (.x(gnt), .thr(gnt_thr));
   assign msk_nxt = xfer ? (gnt_thr << 1) : msk;

   // Selection sees the post-transfer mask so back-to-back grants rotate without a bubble.
   assign mreq    = req & msk_nxt;
   assign sel_src = (|mreq) ? mreq : req;

   thr_rr_thermo #(.WIDTH(WIDTH)) u_sel_thr (.x(sel_src), .thr(sel_thr));
   assign sel_oh = sel_thr & ~(sel_thr << 1);

   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < WIDTH; i++)
         if (sel_oh[i]) sel_idx = sel_idx | IDXW'(i);
   end

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      idx_nxt   = gnt_idx;
      case (state)
         IDLE: begin
            if (|req) begin
               state_nxt = GRANT;
               gnt_nxt   = sel_oh;
               idx_nxt   = sel_idx;
            end
         end
         GRANT: begin
`ifdef THR_RR_ARB_LOCK_EN
            if (xfer) begin
`else
            begin
`endif
               if (|req) begin
                  gnt_nxt = sel_oh;
                  idx_nxt = sel_idx;
               end else begin
                  state_nxt = IDLE;
                  gnt_nxt   = '0;
                  idx_nxt   = '0;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         gnt     <= '0;
         gnt_idx <= '0;
         msk     <= '1;
      end else begin
         state   <= state_nxt;
         gnt     <= gnt_nxt;
         gnt_idx <= idx_nxt;
         msk     <= msk_nxt;
      end
   end

endmodule

// File: tb/tb_thr_rr_arbiter.sv
// Bench for thr_rr_arbiter (WIDTH=4): directed vector table, reset/X sequences, and random
// traffic against a last-winner round-robin reference model.

module tb_thr_rr_arbiter;
   localparam int W = 4;
`ifdef THR_RR_ARB_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] req;
   logic [W-1:0] gnt;
   logic [1:0]   gnt_idx;
   logic         gnt_vld;
   logic         gnt_rdy;

   int passed = 0;
   int total  = 0;

   thr_rr_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
      .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .gnt_rdy(gnt_rdy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] req;
      logic         rdy;
      logic [W-1:0] gnt;
      logic         vld;
   } vec_t;

   vec_t tbl[23];

   // reference model state: index of last accepted requester (-1 = nothing accepted yet)
   int m_last;
   bit m_vld;
   int m_idx;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [1:0] oh2idx(input logic [W-1:0] g);
      logic [1:0] r;
      r = '0;
      for (int i = 0; i < W; i++) if (g[i]) r = 2'(i);
      return r;
   endfunction

   function automatic int pick(input logic [W-1:0] r, input int last);
      for (int i = last + 1; i < W; i++) if (r[i]) return i;
      for (int i = 0; i < W; i++) if (r[i]) return i;
      return -1;
   endfunction

   task automatic model_step(input logic [W-1:0] r, input logic rd);
      bit x;
      x = m_vld && rd;
      if (x) m_last = m_idx;
      if (!m_vld || x || !LOCK) begin
         if (r != '0) begin
            m_vld = 1'b1;
            m_idx = pick(r, m_last);
         end else begin
            m_vld = 1'b0;
            m_idx = 0;
         end
      end
   endtask

   task automatic step(input logic [W-1:0] r, input logic rd);
      @(negedge clk);
      req     = r;
      gnt_rdy = rd;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n   = 1'b0;
      req     = '0;
      gnt_rdy = 1'b0;
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      m_last = -1;
      m_vld  = 1'b0;
      m_idx  = 0;
   endtask

   initial begin
      logic [W-1:0] r;
      logic         rd;
      logic [W-1:0] eg;

      rst_n = 1'b0; req = '0; gnt_rdy = 1'b0;

      // rotation, skip/wrap, backpressure, drain, ready-before-valid
      tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1};
      tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1};
      tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1};
      tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1};
      tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1};
      tbl[5]  = '{4'b1010, 1'b1, 4'b0010, 1'b1};
      tbl[6]  = '{4'b1010, 1'b1, 4'b1000, 1'b1};
      tbl[7]  = '{4'b1010, 1'b1, 4'b0010, 1'b1};
      tbl[8]  = '{4'b1010, 1'b1, 4'b1000, 1'b1};
      tbl[9]  = '{4'b0011, 1'b1, 4'b0001, 1'b1};
      tbl[10] = '{4'b0110, 1'b1, 4'b0010, 1'b1};
      tbl[11] = '{4'b0110, 1'b0, 4'b0010, 1'b1};
      tbl[12] = '{4'b0100, 1'b0, LOCK ? 4'b0010 : 4'b0100, 1'b1};
      tbl[13] = '{4'b0100, 1'b0, LOCK ? 4'b0010 : 4'b0100, 1'b1};
      tbl[14] = '{4'b0110, 1'b0, 4'b0010, 1'b1};
      tbl[15] = '{4'b0100, 1'b0, LOCK ? 4'b0010 : 4'b0100, 1'b1};
      tbl[16] = '{4'b0100, 1'b1, 4'b0100, 1'b1};
      tbl[17] = '{4'b0000, 1'b1, 4'b0000, 1'b0};
      tbl[18] = '{4'b0100, 1'b0, 4'b0100, 1'b1};
      tbl[19] = '{4'b0000, 1'b1, 4'b0000, 1'b0};
      tbl[20] = '{4'b0000, 1'b1, 4'b0000, 1'b0};
      tbl[21] = '{4'b0001, 1'b1, 4'b0001, 1'b1};
      tbl[22] = '{4'b0000, 1'b0, LOCK ? 4'b0001 : 4'b0000, LOCK};

      do_reset();
      #1;
      chk("reset_gnt", 32'(gnt), 32'h0);
      chk("reset_vld", 32'(gnt_vld), 32'h0);
      chk("reset_idx", 32'(gnt_idx), 32'h0);

      for (int k = 0; k < 23; k++) begin
         step(tbl[k].req, tbl[k].rdy);
         chk($sformatf("vec%0d_gnt", k), 32'(gnt), 32'(tbl[k].gnt));
         chk($sformatf("vec%0d_idx", k), 32'(gnt_idx), 32'(oh2idx(tbl[k].gnt)));
         chk($sformatf("vec%0d_vld", k), 32'(gnt_vld), 32'(tbl[k].vld));
      end

      // asynchronous reset in the middle of a held grant
      do_reset();
      step(4'b0100, 1'b0);
      chk("pre_rst_gnt", 32'(gnt), 32'h4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_gnt", 32'(gnt), 32'h0);
      chk("async_rst_idx", 32'(gnt_idx), 32'h0);
      chk("async_rst_vld", 32'(gnt_vld), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step(4'b1111, 1'b0);
      chk("post_rst_gnt", 32'(gnt), 32'h1);
      chk("post_rst_vld", 32'(gnt_vld), 32'h1);

      // unknown bits above the winner must not disturb the grant
      do_reset();
      step(4'bxx10, 1'b0);
      chk("xtol_gnt", 32'(gnt), 32'h2);
      chk("xtol_idx", 32'(gnt_idx), 32'h1);
      chk("xtol_known", 32'($isunknown({gnt, gnt_idx})), 32'h0);

      // random traffic against the reference model
      do_reset();
      for (int n = 0; n < 600; n++) begin
         r  = 4'($urandom);
         if ($urandom_range(0, 7) == 0) r = '0;
         rd = ($urandom_range(0, 3) != 0);
         step(r, rd);
         model_step(r, rd);
         eg = m_vld ? 4'(1 << m_idx) : 4'b0;
         chk($sformatf("rnd%0d_gnt", n), 32'(gnt), 32'(eg));
         chk($sformatf("rnd%0d_idx", n), 32'(gnt_idx), 32'(m_idx));
         chk($sformatf("rnd%0d_vld", n), 32'(gnt_vld), 32'(m_vld));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
